// File: rtl/item_arbiter_pkg.sv
// Shared types and FSM encodings for the round-robin item arbiter.
package item_arbiter_pkg;

    typedef logic [2:0] item_t;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/item_arbiter_if.sv
// Producer-to-consumer item channel: N_REQ requester lanes in, one registered lane out.
interface item_arbiter_if #(
    parameter int N_REQ = 4
);
    import item_arbiter_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    item_t [N_REQ-1:0]       req_item;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    item_t                   out_item;
    logic [ID_W-1:0]         out_id;
    logic                    out_ready;

    modport master (
        input  req_valid, req_item, out_ready,
        output req_ready, out_valid, out_item, out_id
    );

    modport slave (
        output req_valid, req_item, out_ready,
        input  req_ready, out_valid, out_item, out_id
    );

endinterface

// File: rtl/item_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = idx;
            end
        end
    end

endmodule

// File: rtl/item_arbiter.sv
// Round-robin arbiter with optional burst lock feeding one registered output stage.
module item_arbiter
    import item_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int BURST = 1,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input logic           clk,
    input logic           rst_n,
    item_arbiter_if.master bus
);

    localparam int CNT_W = (BURST > 1) ? $clog2(BURST + 1) : 1;

    logic [0:0]       state_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  owner_q;
    logic [CNT_W-1:0] cnt_q;

    logic             vld_p1;
    item_t            item_p1;
    logic [ID_W-1:0]  id_p1;

    logic [N_REQ-1:0] rr_grant;
    logic [ID_W-1:0]  rr_id;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gid;
    logic             can_load;
    logic             accept;
    logic             owner_valid;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] cur);
        return (cur == ID_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
    endfunction

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .id    (rr_id)
    );

    assign can_load    = ~vld_p1 | bus.out_ready;
    assign owner_valid = bus.req_valid[owner_q];

    // While locked only the owner may win; a dropped owner valid yields no grant.
    always_comb begin
        grant = '0;
        gid   = '0;
        if (state_q == ST_LOCK) begin
            if (owner_valid) begin
                grant[owner_q] = 1'b1;
                gid            = owner_q;
            end
        end else begin
            grant = rr_grant;
            gid   = rr_id;
        end
    end

    assign accept        = (|grant) & can_load;
    assign bus.req_ready = rst_n ? (grant & {N_REQ{can_load}}) : '0;

    // Stage p1: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            item_p1 <= '0;
            id_p1   <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            item_p1 <= bus.req_item[gid];
            id_p1   <= gid;
        end else if (bus.out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (accept) begin
                        if (BURST > 1) begin
                            state_q <= ST_LOCK;
                            owner_q <= gid;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            ptr_q <= next_id(gid);
                        end
                    end
                end
                ST_LOCK: begin
                    if (!owner_valid) begin
                        ptr_q   <= next_id(owner_q);
                        state_q <= ST_ARB;
                        cnt_q   <= '0;
                    end else if (accept) begin
                        // This accept is the last beat the owner may take.
                        if (cnt_q == CNT_W'(BURST - 1)) begin
                            ptr_q   <= next_id(owner_q);
                            state_q <= ST_ARB;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_item  = item_p1;
    assign bus.out_id    = id_p1;

endmodule
